// File: rtl/mips32_shift_seq_if.sv
// Request/response bundle between a shift initiator and the sequential shifter.
interface mips32_shift_seq_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned AMT_WIDTH  = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] shift_in;
  logic [AMT_WIDTH-1:0]  shift_amount;
  logic [1:0]            shift_op;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] shift_out;

  modport master (
    output req_valid, shift_in, shift_amount, shift_op, resp_ready,
    input  req_ready, resp_valid, shift_out
  );

  modport slave (
    input  req_valid, shift_in, shift_amount, shift_op, resp_ready,
    output req_ready, resp_valid, shift_out
  );
endinterface

// File: rtl/mips32_shift_seq.sv
// Bit-serial MIPS32 shifter: one bit position per clock, valid/ready on both the
// request and response side, result identical to the combinational shifter.
module mips32_shift_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned AMT_WIDTH  = 5
) (
  input logic               clk,
  input logic               rst,
  mips32_shift_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  state_t                state_q;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] work_q;
  logic [AMT_WIDTH-1:0]  count_q;
  logic [1:0]            op_q;
  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic                  accept_c;
  logic [DATA_WIDTH-1:0] step_c;

  // req_ready_q is only high in IDLE, so it doubles as the state qualifier.
  assign accept_c = req_ready_q & bus.req_valid;

  // One-position move of the work register for the latched op.
  always_comb begin
    step_c = work_q;
    case (op_q)
      OP_SLL:  step_c = {work_q[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  step_c = {1'b0, work_q[DATA_WIDTH-1:1]};
      OP_SRA:  step_c = {work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
      OP_ROR:  step_c = {work_q[0], work_q[DATA_WIDTH-1:1]};
      default: step_c = work_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A count of 0 is treated as the final step so SHIFT can never lock up.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = (bus.shift_amount == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (count_q <= AMT_WIDTH'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (resp_valid_q && bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs. An amount-0 request enters DONE
  // straight from IDLE; resp_valid is held back one cycle there so every
  // request sees at least one cycle of latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q       <= '0;
      count_q      <= '0;
      op_q         <= OP_SLL;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      if (accept_c) begin
        work_q  <= bus.shift_in;
        count_q <= bus.shift_amount;
        op_q    <= bus.shift_op;
      end else if (state_q == SHIFT) begin
        work_q  <= step_c;
        count_q <= count_q - AMT_WIDTH'(1);
      end
      req_ready_q  <= (state_d == IDLE);
      resp_valid_q <= (state_d == DONE) && (state_q != IDLE);
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.shift_out  = work_q;

endmodule

// File: tb/tb_mips32_shift_seq.sv
// Directed and randomized checks of mips32_shift_seq against a shift reference model.
module tb_mips32_shift_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips32_shift_seq_if #(.DATA_WIDTH(32), .AMT_WIDTH(5)) bus ();

  mips32_shift_seq #(.DATA_WIDTH(32), .AMT_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: the combinational MIPS32 shift, written with plain operators.
  function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [4:0] a,
                                            input logic [1:0] op);
    logic [63:0] dbl;
    case (op)
      2'b00:   return x << a;
      2'b01:   return x >> a;
      2'b10:   return 32'($signed(x) >>> a);
      default: begin
        dbl = {x, x} >> a;
        return dbl[31:0];
      end
    endcase
  endfunction

  task automatic scramble_req();
    bus.shift_in     = $urandom;
    bus.shift_amount = 5'($urandom);
    bus.shift_op     = 2'($urandom);
  endtask

  // Present a request and return just after its acceptance edge.
  task automatic accept_req(input logic [31:0] x, input logic [4:0] a, input logic [1:0] op);
    int waitc = 0;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.shift_in     = x;
    bus.shift_amount = a;
    bus.shift_op     = op;
    while (bus.req_ready !== 1'b1 && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    check_val("accept_wait", 32'(waitc < 100), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'($urandom);
    scramble_req();
  endtask

  // Wait for the response, check latency and value, stall it, then consume it.
  task automatic collect(input string tag, input logic [31:0] exp, input logic [4:0] a,
                         input int hold);
    int          lat = 0;
    logic [31:0] held;
    @(negedge clk);
    while (bus.resp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_val({tag, "_lat"}, 32'(lat), (a == 5'd0) ? 32'd1 : 32'(a));
    check_val({tag, "_out"}, bus.shift_out, exp);
    held = bus.shift_out;
    for (int i = 0; i < hold; i++) begin
      bus.resp_ready = 1'b0;
      bus.req_valid  = 1'b1;
      scramble_req();
      @(negedge clk);
      check_val({tag, "_hold_valid"}, 32'(bus.resp_valid), 32'd1);
      check_val({tag, "_hold_out"}, bus.shift_out, held);
      check_val({tag, "_hold_rdy"}, 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b0;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    check_val({tag, "_post_valid"}, 32'(bus.resp_valid), 32'd0);
    check_val({tag, "_post_rdy"}, 32'(bus.req_ready), 32'd1);
    check_val({tag, "_post_out"}, bus.shift_out, held);
  endtask

  task automatic run(input string tag, input logic [31:0] x, input logic [4:0] a,
                     input logic [1:0] op, input logic [31:0] exp, input int hold);
    accept_req(x, a, op);
    collect(tag, exp, a, hold);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          gap;
    int          hold;
    logic [31:0] x;
    logic [4:0]  a;
    logic [1:0]  op;
    logic        saw_valid;

    bus.req_valid    = 1'b0;
    bus.resp_ready   = 1'b0;
    bus.shift_in     = '0;
    bus.shift_amount = '0;
    bus.shift_op     = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out", bus.shift_out, 32'h0);
    check_val("rst_valid", 32'(bus.resp_valid), 32'd0);
    check_val("rst_rdy", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_val("rel_rdy0", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    check_val("rel_rdy1", 32'(bus.req_ready), 32'd1);

    // Op sweep
    run("sll4",  32'hcfcfcfcf, 5'd4,  2'b00, 32'hfcfcfcf0, 0);
    run("srl8",  32'hcfcfcfcf, 5'd8,  2'b01, 32'h00cfcfcf, 0);
    run("sra12", 32'hcfcfcfcf, 5'd12, 2'b10, 32'hfffcfcfc, 0);
    run("ror12", 32'hcfcfcfcf, 5'd12, 2'b11, 32'hfcfcfcfc, 0);

    // Boundaries
    for (int o = 0; o < 4; o++) begin
      run("amt0", 32'hcfcfcfcf, 5'd0, 2'(o), 32'hcfcfcfcf, 0);
    end
    run("srl31", 32'hcfcfcfcf, 5'd31, 2'b01, 32'h00000001, 0);
    run("sra31", 32'hcfcfcfcf, 5'd31, 2'b10, 32'hffffffff, 0);
    run("ror16", 32'hcfcfcfcf, 5'd16, 2'b11, 32'hcfcfcfcf, 0);
    run("sll31", 32'hcfcfcfcf, 5'd31, 2'b00, 32'h80000000, 0);

    // Response backpressure
    run("bp", 32'hcfcfcfcf, 5'd7, 2'b10, 32'hff9f9f9f, 10);

    // Reset in the middle of an operation
    accept_req(32'hcfcfcfcf, 5'd20, 2'b00);
    bus.req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_val("mid_rst_out", bus.shift_out, 32'h0);
    check_val("mid_rst_valid", 32'(bus.resp_valid), 32'd0);
    check_val("mid_rst_rdy", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("mid_rel_rdy", 32'(bus.req_ready), 32'd1);
    saw_valid = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) saw_valid = 1'b1;
    end
    check_val("mid_no_resp", 32'(saw_valid), 32'd0);
    check_val("mid_out_zero", bus.shift_out, 32'h0);

    // Random compare with request and response gaps
    for (int n = 0; n < 1000; n++) begin
      gap  = $urandom_range(0, 2);
      hold = $urandom_range(0, 3);
      x    = $urandom;
      a    = 5'($urandom);
      op   = 2'($urandom);
      repeat (gap) @(negedge clk);
      run("rnd", x, a, op, ref_shift(x, a, op), hold);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
